mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the 24-bit word memory port (addr/din/we/dout). Takes single
//  read/write requests, or fill requests (one value to N consecutive words), over a
//  valid/ready handshake. Drives the memory and returns one response per request.
//  Sits between the CPU datapath and the data memory.
// PARAMETERS
//  DATA_W  24   data word width
//  ADDR_W  24   memory address width
//  DEPTH   256  number of implemented words; addr >= DEPTH is out of range
//  LEN_W   9    width of fill length (max 256)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when valid&ready
//  req_op     in   2       00 read, 01 write, 10 fill, 11 reserved
//  req_addr   in   ADDR_W  word address (start address for fill)
//  req_wdata  in   DATA_W  write/fill data
//  req_len    in   LEN_W   fill word count; ignored for read/write
//  rsp_valid  out  1       response present; held until rsp_ready
//  rsp_ready  in   1       response consumed when valid&ready
//  rsp_rdata  out  DATA_W  read data; 0 for write/fill/error
//  rsp_err    out  1       request rejected or verify mismatch
//  busy       out  1       high in any state other than IDLE
//  mem_addr   out  ADDR_W  to memory addr
//  mem_din    out  DATA_W  to memory din
//  mem_we     out  1       to memory we; write lands on the edge where it is high
//  mem_dout   in   DATA_W  from memory; combinational read of mem[mem_addr]
// BEHAVIOUR
//  - Reset (async): state IDLE. All outputs 0 except req_ready=1. mem_we drops immediately.
//  - FSM IDLE->{RD,WR,FILL,RESP}; RD->RESP; WR->RESP (or VERIFY); FILL->FILL/RESP; RESP->IDLE.
//  - IDLE: req_ready=1. On acceptance, latch op/addr/wdata/len.
//    - Checks on acceptance: err if op=11, addr>=DEPTH, fill len=0, or addr+len>DEPTH.
//      Perform the addr+len sum at ADDR_W+1 bits (no wrap).
//    - On err: go directly to RESP with rsp_err=1, rsp_rdata=0. mem_we is never asserted.
//  - req_ready=0 in every state other than IDLE.
//  - RD, 1 cycle: mem_addr=addr, mem_we=0. mem_dout is captured into rsp_rdata on exit.
//    rsp_valid rises 2 cycles after the accept cycle.
//  - WR, 1 cycle: mem_addr=addr, mem_din=wdata, mem_we=1.
//  - FILL, len cycles: mem_we=1 every cycle, mem_din=wdata.
//    mem_addr steps addr, addr+1, ..., addr+len-1. A down-counter decides the last beat.
//  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready.
//    Then go to IDLE. A new request may be accepted the cycle after.
//  - mem_we=1 only in WR/FILL. In IDLE/RESP: mem_addr and mem_din hold their last value, mem_we=0.
//  - Reset mid-FILL: words already written keep their value; no further writes.
// CONFIGURATION
//  MEM_WRITE_VERIFY_EN defined:
//    - WR is followed by 1 VERIFY cycle (mem_addr=addr, mem_we=0).
//    - If mem_dout != wdata: rsp_err=1 and rsp_rdata=mem_dout; otherwise rsp_rdata=0.
//    - FILL is not verified.
//  Not defined: no VERIFY state. WR goes straight to RESP. Write latency equals read latency.
// STRUCTURE
//  - Package mem_access_pkg: op encodings (OP_RD/OP_WR/OP_FILL/OP_RSVD), FSM state enum,
//    DEPTH default constant.
//  - Sub-module mem_req_check: combinational op/range/len check, outputs req_err.
//  - Everything else lives in the top module.
// TESTING
//  - Write 0x00ABCD @5, then read @5 -> rdata=0x00ABCD, err=0.
//    mem_we high exactly 1 cycle with mem_addr=5.
//  - Fill @250 len=6 data=0x123456 -> mem_we high 6 consecutive cycles, addr 250..255.
//    Read @255 -> 0x123456.
//  - Fill @250 len=7 -> err=1, mem_we never high. Same for len=0, op=11, and read @256.
//  - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata/err stable, req_ready=0.
//    A pending req_valid is not accepted until 1 cycle after the rsp handshake.
//  - Assert rst_n=0 during fill beat 3 of len=8 @0 -> mem_we=0 at once.
//    Words 0..2 written, 3..7 unchanged, req_ready=1.
//  - MEM_WRITE_VERIFY_EN: memory model corrupts the write -> err=1, rdata=corrupt value.
//    Without the macro: write rsp_valid rises 2 cycles after accept.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Shared op encodings, FSM state type and default memory depth for
//           the memory access controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_FILL = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam int unsigned MEM_DEPTH = 256;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_WR     = 3'd2,
      ST_VERIFY = 3'd3,
      ST_FILL   = 3'd4,
      ST_RESP   = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_check.sv
// ============================================================================
// Module  : mem_req_check
// Brief   : Combinational request legality check (op, address range, fill
//           length and fill end address).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_check
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 9,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   output logic              req_err
);

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0] w_end;
   logic            w_addr_oor;

   // One extra bit so a start address near the top cannot wrap past the check
   assign w_end      = {1'b0, addr} + {{(ADDR_W+1-LEN_W){1'b0}}, len};
   assign w_addr_oor = ({1'b0, addr} >= c_depth);

   always_comb begin
      req_err = 1'b0;
      case (op)
         OP_RD,
         OP_WR:   req_err = w_addr_oor;
         OP_FILL: req_err = w_addr_oor | (len == '0) | (w_end > c_depth);
         default: req_err = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : Memory port initiator for single read/write and fill requests over
//           a valid/ready handshake. Optional MEM_WRITE_VERIFY_EN read-back.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 24,
   parameter int DEPTH  = MEM_DEPTH,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t            r_state;
   logic [LEN_W-1:0]  r_cnt;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_busy;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_din;
   logic              r_mem_we;
   logic              w_req_err;

   mem_req_check #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .DEPTH  (DEPTH)
   ) u_check (
      .op      (req_op),
      .addr    (req_addr),
      .len     (req_len),
      .req_err (w_req_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_mem_we    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_cnt       <= req_len - LEN_W'(1);
                  if (w_req_err) begin
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     r_mem_addr <= req_addr;
                     case (req_op)
                        OP_RD: begin
                           r_state <= ST_RD;
                        end
                        OP_WR: begin
                           r_state   <= ST_WR;
                           r_mem_din <= req_wdata;
                           r_mem_we  <= 1'b1;
                        end
                        default: begin
                           r_state   <= ST_FILL;
                           r_mem_din <= req_wdata;
                           r_mem_we  <= 1'b1;
                        end
                     endcase
                  end
               end
            end

            ST_RD: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= mem_dout;
            end

            ST_WR: begin
               r_mem_we <= 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
               r_state  <= ST_VERIFY;
`else
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= '0;
`endif
            end

`ifdef MEM_WRITE_VERIFY_EN
            // mem_din still holds the written word, so it is the reference
            ST_VERIFY: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               if (mem_dout != r_mem_din) begin
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= mem_dout;
               end else begin
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
               end
            end
`endif

            ST_FILL: begin
               if (r_cnt == '0) begin
                  r_mem_we    <= 1'b0;
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
               end else begin
                  r_mem_addr <= r_mem_addr + ADDR_W'(1);
                  r_cnt      <= r_cnt - LEN_W'(1);
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state     <= ST_IDLE;
               r_mem_we    <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;
   assign mem_we    = r_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Self-checking bench for mem_access_ctrl with a behavioural memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [23:0] req_addr, req_wdata;
   logic [8:0]  req_len;
   logic        rsp_valid, rsp_ready;
   logic [23:0] rsp_rdata;
   logic        rsp_err, busy;
   logic [23:0] mem_addr, mem_din, mem_dout;
   logic        mem_we;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_we    (mem_we),
      .mem_dout  (mem_dout)
   );

   // Behavioural memory; corrupt flips bit 8 of written data
   logic [23:0] mem [0:255];
   logic        init_done = 1'b0;
   logic        corrupt   = 1'b0;
   int          we_total  = 0;
   logic [23:0] we_log [0:1023];

   assign mem_dout = (mem_addr < 24'd256) ? mem[mem_addr[7:0]] : 24'h0;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 24'hA00000 | 24'(i);
         init_done <= 1'b1;
      end else if (mem_we) begin
         if (mem_addr < 24'd256)
            mem[mem_addr[7:0]] <= mem_din ^ (corrupt ? 24'h000100 : 24'h0);
         if (we_total < 1024) we_log[we_total] <= mem_addr;
         we_total <= we_total + 1;
      end
   end

`ifdef MEM_WRITE_VERIFY_EN
   localparam int WR_LAT = 3;
`else
   localparam int WR_LAT = 2;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic transact(input logic [1:0] op, input logic [23:0] addr,
                           input logic [23:0] wd, input logic [8:0] len,
                           output logic err, output logic [23:0] rdata,
                           output int lat, output int wes, output int s);
      int t;
      s = we_total;
      req_op = op; req_addr = addr; req_wdata = wd; req_len = len;
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      if (!req_ready) chk("req_ready_timeout", 0, 1);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
      err   = rsp_err;
      rdata = rsp_rdata;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      wes = we_total - s;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [23:0] addr;
      logic [23:0] wdata;
      logic [8:0]  len;
      logic        err;
      logic [23:0] rdata;
      int          lat;
      int          wes;
   } vec_t;

   vec_t vt [17];

   initial begin
      logic        e;
      logic [23:0] rd;
      int          lat, wes, s, t;
      bit          bad;

      vt[0]  = '{2'b01, 24'd5,        24'h00ABCD, 9'd0,   1'b0, 24'h000000, WR_LAT, 1};
      vt[1]  = '{2'b00, 24'd5,        24'h0,      9'd0,   1'b0, 24'h00ABCD, 2,      0};
      vt[2]  = '{2'b10, 24'd250,      24'h123456, 9'd6,   1'b0, 24'h000000, 7,      6};
      vt[3]  = '{2'b00, 24'd255,      24'h0,      9'd0,   1'b0, 24'h123456, 2,      0};
      vt[4]  = '{2'b00, 24'd249,      24'h0,      9'd0,   1'b0, 24'hA000F9, 2,      0};
      vt[5]  = '{2'b10, 24'd250,      24'h654321, 9'd7,   1'b1, 24'h000000, 1,      0};
      vt[6]  = '{2'b10, 24'd10,       24'h654321, 9'd0,   1'b1, 24'h000000, 1,      0};
      vt[7]  = '{2'b11, 24'd5,        24'h654321, 9'd1,   1'b1, 24'h000000, 1,      0};
      vt[8]  = '{2'b00, 24'd256,      24'h0,      9'd0,   1'b1, 24'h000000, 1,      0};
      vt[9]  = '{2'b01, 24'h800005,   24'h111111, 9'd0,   1'b1, 24'h000000, 1,      0};
      vt[10] = '{2'b01, 24'd255,      24'hFFFFFF, 9'd5,   1'b0, 24'h000000, WR_LAT, 1};
      vt[11] = '{2'b00, 24'd255,      24'h0,      9'd0,   1'b0, 24'hFFFFFF, 2,      0};
      vt[12] = '{2'b10, 24'd255,      24'h777777, 9'd1,   1'b0, 24'h000000, 2,      1};
      vt[13] = '{2'b00, 24'd255,      24'h0,      9'd0,   1'b0, 24'h777777, 2,      0};
      vt[14] = '{2'b10, 24'd1,        24'h00000F, 9'd255, 1'b0, 24'h000000, 256,    255};
      vt[15] = '{2'b00, 24'd0,        24'h0,      9'd0,   1'b0, 24'hA00000, 2,      0};
      vt[16] = '{2'b00, 24'd200,      24'h0,      9'd0,   1'b0, 24'h00000F, 2,      0};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = 2'b00; req_addr = '0; req_wdata = '0; req_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_outputs", {rsp_valid, rsp_err, busy, mem_we, rsp_rdata, mem_addr, mem_din}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         transact(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].len, e, rd, lat, wes, s);
         chk($sformatf("v%0d_err", i), e, vt[i].err);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
         chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d_we_cycles", i), wes, vt[i].wes);
         if (vt[i].wes > 0) begin
            bad = 1'b0;
            for (int k = 0; k < vt[i].wes; k++)
               if (we_log[s+k] !== vt[i].addr + 24'(k)) bad = 1'b1;
            chk($sformatf("v%0d_we_addr", i), bad, 0);
         end
      end

      // Backpressure with a pending request behind the held response
      req_op = 2'b00; req_addr = 24'd0; req_len = '0; req_valid = 1'b1;
      @(negedge clk);
      req_addr = 24'd200;
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_hold", c), {rsp_valid, rsp_err, req_ready, busy, rsp_rdata},
             {1'b1, 1'b0, 1'b0, 1'b1, 24'hA00000});
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle_gap", {rsp_valid, req_ready, busy}, {1'b0, 1'b1, 1'b0});
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_pending_accepted", {req_ready, busy}, {1'b0, 1'b1});
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
      chk("bp_pending_rdata", {rsp_valid, rsp_rdata}, {1'b1, 24'h00000F});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset during the fourth fill beat (mem_addr = 3)
      req_op = 2'b10; req_addr = 24'd0; req_wdata = 24'h5A5A5A; req_len = 9'd8;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      t = 0;
      while (!(mem_we && mem_addr == 24'd3) && t < 20) begin @(negedge clk); t++; end
      chk("rstfill_reached_beat", {mem_we, mem_addr}, {1'b1, 24'd3});
      rst_n = 1'b0;
      #1;
      chk("rstfill_we_drop", mem_we, 0);
      chk("rstfill_ready", {req_ready, busy, rsp_valid}, {1'b1, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int w = 0; w < 8; w++)
         chk($sformatf("rstfill_mem%0d", w), mem[w], (w < 3) ? 24'h5A5A5A : 24'h00000F);
      @(negedge clk);
      transact(2'b00, 24'd2, 24'h0, 9'd0, e, rd, lat, wes, s);
      chk("rstfill_rd2", rd, 24'h5A5A5A);
      transact(2'b00, 24'd3, 24'h0, 9'd0, e, rd, lat, wes, s);
      chk("rstfill_rd3", rd, 24'h00000F);

`ifdef MEM_WRITE_VERIFY_EN
      corrupt = 1'b1;
      transact(2'b01, 24'd7, 24'h111111, 9'd0, e, rd, lat, wes, s);
      corrupt = 1'b0;
      chk("verify_err", e, 1);
      chk("verify_rdata", rd, 24'h111011);
      chk("verify_latency", lat, 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
